// File: rtl/acc8_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : acc8_ctrl (with helper adder cla8)                       |
// | Description : Length-framed 8-bit accumulator. A run is opened by      |
// |               start/len in IDLE, accepts exactly len operands over a   |
// |               valid/ready handshake, sums them through a carry-        |
// |               lookahead adder and closes with a one-cycle done pulse.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// | Ports (acc8_ctrl)                                                      |
// |   clk       in   1      rising-edge clock                              |
// |   reset     in   1      asynchronous active-high reset                 |
// |   start     in   1      begin a run (looked at in IDLE only)           |
// |   len       in   LEN_W  operand count, captured with start            |
// |   in_valid  in   1      operand present on in_data                     |
// |   in_data   in   8      unsigned operand                               |
// |   in_ready  out  1      operand accepted when in_valid is also high    |
// |   acc       out  8      registered running sum                         |
// |   carry     out  1      sticky carry-out of any add in this run        |
// |   busy      out  1      run in progress (ACCUM or DONE)                |
// |   done      out  1      single-cycle run-complete pulse                |
// +------------------------------------------------------------------------+
// | Build option                                                           |
// |   ACC_SAT_EN : when defined, an add that carries out saturates acc     |
// |                to 8'hFF instead of wrapping modulo 256.                |
// +------------------------------------------------------------------------+

// 8-bit carry-lookahead adder built from two 4-bit lookahead groups joined
// by a second lookahead level, so no carry ripples between bit positions.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] w_g;      // bit generate
  logic [7:0] w_p;      // bit propagate
  logic [7:0] w_c;      // carry into each bit
  logic [1:0] w_grp_g;  // group generate
  logic [1:0] w_grp_p;  // group propagate
  logic       w_c4;     // carry into the upper group

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Second-level lookahead: carries into each group come straight from ci
  // and the group terms, never from another group's internal carries.
  assign w_c4 = w_grp_g[0] | (w_grp_p[0] & ci);
  assign co   = w_grp_g[1]
              | (w_grp_p[1] & w_grp_g[0])
              | (w_grp_p[1] & w_grp_p[0] & ci);

  generate
    for (genvar k = 0; k < 2; k++) begin : g_grp
      localparam int B = 4 * k;
      logic w_cin;

      if (k == 0) begin : g_cin_lo
        assign w_cin = ci;
      end else begin : g_cin_hi
        assign w_cin = w_c4;
      end

      assign w_c[B]   = w_cin;
      assign w_c[B+1] = w_g[B]
                      | (w_p[B] & w_cin);
      assign w_c[B+2] = w_g[B+1]
                      | (w_p[B+1] & w_g[B])
                      | (w_p[B+1] & w_p[B] & w_cin);
      assign w_c[B+3] = w_g[B+2]
                      | (w_p[B+2] & w_g[B+1])
                      | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_cin);

      assign w_grp_g[k] = w_g[B+3]
                        | (w_p[B+3] & w_g[B+2])
                        | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
      assign w_grp_p[k] = &w_p[B+3:B];
    end
  endgenerate

  assign s = w_p ^ w_c;

endmodule

module acc8_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       acc,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q,   acc_d;
  logic             carry_q, carry_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;

  logic [7:0]       w_sum_s;
  logic             w_sum_co;

  // The adder always sees the current sum; its result is only committed
  // on a transfer, so outside ACCUM it simply idles.
  cla8 u_cla8 (
    .a  (acc_q),
    .b  (in_data),
    .ci (1'b0),
    .s  (w_sum_s),
    .co (w_sum_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 8'h00;
          carry_d = 1'b0;
          cnt_d   = len;
          // An empty run skips ACCUM entirely and never raises in_ready.
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end

      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
`ifdef ACC_SAT_EN
          // Once pinned at 8'hFF any further non-zero add carries out
          // again, so the sum stays saturated for the rest of the run.
          acc_d = w_sum_co ? 8'hFF : w_sum_s;
`else
          acc_d = w_sum_s;
`endif
          carry_d = carry_q | w_sum_co;
          cnt_d   = cnt_q - LEN_W'(1);
          // Leaving on the last operand means the counter stops at zero
          // and never wraps.
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign acc   = acc_q;
  assign carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_acc8_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_acc8_ctrl                                             |
// | Description : Self-checking bench for acc8_ctrl: table of directed     |
// |               runs, hand sequences for reset abort and ignored start,  |
// |               and random runs checked against an arithmetic model.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_acc8_ctrl;

  localparam int LEN_W = 4;
`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [7:0] ops_t [16];
  typedef int         gaps_t [16];

  typedef struct {
    string      name;
    int         len;
    ops_t       ops;
    gaps_t      gaps;
    logic [7:0] exp_acc;
    logic       exp_carry;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [7:0]       acc;
  logic             carry;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  acc8_ctrl #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .acc      (acc),
    .carry    (carry),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Counts done pulses at mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the wrapped sum carries out at least once exactly when the
  // true sum reaches 256; with saturation the sum pins at 255 from then on.
  function automatic void model(input ops_t ops, input int n,
                                output logic [7:0] a, output logic c);
    int total = 0;
    for (int i = 0; i < n; i++) total += int'(ops[i]);
    c = (total >= 256);
    if (total >= 256) a = SAT ? 8'hFF : 8'(total % 256);
    else              a = 8'(total);
  endfunction

  task automatic run(input string tag, input int L, input ops_t ops, input gaps_t gaps,
                     input bit noisy, input logic [7:0] exp_acc, input logic exp_carry);
    int d0;
    logic [7:0] pa;
    logic pc;
    d0 = done_cnt;
    start = 1'b1;
    len = L[LEN_W-1:0];
    tick();
    if (noisy) len = 4'd2;   // start stays high with a different len: must be ignored
    else start = 1'b0;
    if (L == 0) begin
      chk({tag, " len0 done"}, done, 1);
      chk({tag, " len0 in_ready"}, in_ready, 0);
    end else begin
      chk({tag, " busy"}, busy, 1);
      for (int i = 0; i < L; i++) begin
        for (int g = 0; g < gaps[i]; g++) begin
          chk({tag, " gap in_ready"}, in_ready, 1);
          tick();
        end
        model(ops, i, pa, pc);
        chk({tag, " acc before xfer"}, acc, pa);
        in_valid = 1'b1;
        in_data = ops[i];
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        if (i < L - 1) chk({tag, " no early done"}, done, 0);
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " in_ready in done"}, in_ready, 0);
      chk({tag, " busy in done"}, busy, 1);
    end
    chk({tag, " acc"}, acc, exp_acc);
    chk({tag, " carry"}, carry, exp_carry);
    tick();
    start = 1'b0;
    chk({tag, " done low"}, done, 0);
    chk({tag, " busy low"}, busy, 0);
    chk({tag, " done count"}, done_cnt - d0, 1);
    // Operands offered in IDLE must not be taken.
    in_valid = 1'b1;
    in_data = 8'h33;
    tick();
    chk({tag, " idle in_ready"}, in_ready, 0);
    tick();
    in_valid = 1'b0;
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " hold acc"}, acc, exp_acc);
    chk({tag, " hold carry"}, carry, exp_carry);
  endtask

  function automatic vec_t mk(input string n, input int L, input int o0, input int o1,
                              input int o2, input int gap1, input int ea, input bit ec);
    vec_t v;
    v.name = n;
    v.len = L;
    for (int i = 0; i < 16; i++) begin
      v.ops[i] = 8'h00;
      v.gaps[i] = 0;
    end
    v.ops[0] = 8'(o0);
    v.ops[1] = 8'(o1);
    v.ops[2] = 8'(o2);
    v.gaps[1] = gap1;
    v.exp_acc = 8'(ea);
    v.exp_carry = ec;
    return v;
  endfunction

  initial begin
    vec_t vt[8];
    ops_t ops;
    gaps_t gaps;
    logic [7:0] ea;
    logic ec;
    int d0;
    int L;

    vt[0] = mk("sum_10_20_30", 3, 10, 20, 30, 0, 60, 1'b0);
    vt[1] = mk("ovf_200_100", 2, 200, 100, 0, 0, SAT ? 255 : 44, 1'b1);
    vt[2] = mk("gap_5_7", 2, 5, 7, 0, 4, 12, 1'b0);
    vt[3] = mk("len0", 0, 0, 0, 0, 0, 0, 1'b0);
    vt[4] = mk("single_255", 1, 255, 0, 0, 0, 255, 1'b0);
    vt[5] = mk("wrap_255_1", 2, 255, 1, 0, 0, SAT ? 255 : 0, 1'b1);
    vt[6] = mk("max_len15", 15, 0, 0, 0, 0, 255, 1'b0);
    for (int i = 0; i < 15; i++) vt[6].ops[i] = 8'd17;
    vt[7] = mk("sat_then_zero", 3, 250, 10, 0, 1, SAT ? 255 : 4, 1'b1);

    // Asynchronous reset, observed before any clock edge.
    #2 reset = 1'b1;
    #2;
    chk("reset acc", acc, 8'h00);
    chk("reset carry", carry, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset in_ready", in_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post-reset idle", busy, 0);

    for (int v = 0; v < 8; v++) begin
      run(vt[v].name, vt[v].len, vt[v].ops, vt[v].gaps, 1'b0, vt[v].exp_acc, vt[v].exp_carry);
    end

    // Reset in the middle of a run aborts it without a done pulse.
    d0 = done_cnt;
    start = 1'b1;
    len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd200;
    tick();
    in_data = 8'd100;
    tick();
    in_valid = 1'b0;
    chk("abort pre carry", carry, 1);
    chk("abort pre busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort acc", acc, 8'h00);
    chk("abort carry", carry, 0);
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 0);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("abort stays idle", busy, 0);
    chk("abort no done", done_cnt - d0, 0);
    for (int i = 0; i < 16; i++) begin
      ops[i] = 8'h00;
      gaps[i] = 0;
    end
    ops[0] = 8'd9;
    run("after_abort", 1, ops, gaps, 1'b0, 8'd9, 1'b0);

    // start held high (len=2) through ACCUM and DONE of a len=7 run.
    for (int i = 0; i < 7; i++) begin
      ops[i] = 8'(i + 1);
      gaps[i] = (i == 3) ? 2 : 0;
    end
    run("start_ignored", 7, ops, gaps, 1'b1, 8'd28, 1'b0);

    // Random runs against the arithmetic model.
    for (int r = 0; r < 30; r++) begin
      L = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        ops[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 40));
        gaps[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      model(ops, L, ea, ec);
      run($sformatf("rand%0d", r), L, ops, gaps, (L > 0) && ($urandom_range(0, 3) == 0), ea, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc8_ctrl.md
ACC8_CTRL -- requirements
Module: acc8_ctrl

Interface
REQ-001 Parameter: LEN_W, 4, width of the operand-count input len and the internal down-counter.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin one accumulation run; sampled only in IDLE.
REQ-005 Port: len  input  LEN_W  number of operands in the run; sampled with start.
REQ-006 Port: in_valid  input  1  operand present on in_data.
REQ-007 Port: in_data  input  8  unsigned operand.
REQ-008 Port: in_ready  output  1  block accepts an operand this cycle.
REQ-009 Port: acc  output  8  registered running sum.
REQ-010 Port: carry  output  1  sticky flag: any add in the current run produced carry-out.
REQ-011 Port: busy  output  1  high in ACCUM and DONE.
REQ-012 Port: done  output  1  single-cycle run-complete pulse.

Function
REQ-013 Adder datapath SHALL be one cla8 instance: a=acc, b=in_data, ci=0; its s and co are consumed by this block's registers.
REQ-014 FSM states SHALL be IDLE, ACCUM, DONE, registered on clk.
REQ-015 IDLE: in_ready=0, busy=0, done=0; acc and carry hold their previous values.
REQ-016 IDLE, start=1, len!=0: next cycle acc=0, carry=0, counter=len, state ACCUM.
REQ-017 IDLE, start=1, len==0: next cycle acc=0, carry=0, state DONE (no operands accepted).
REQ-018 ACCUM: in_ready=1 combinationally in every cycle; a transfer occurs when in_valid&&in_ready at the clock edge.
REQ-019 On transfer: acc<=cla8.s (modulo 256), carry<=carry|cla8.co, counter<=counter-1.
REQ-020 Transfer with counter==1: state DONE next cycle; in_ready=0 from that cycle on.
REQ-021 ACCUM with in_valid=0: no state change; run waits indefinitely.
REQ-022 DONE: done=1, busy=1, in_ready=0, for exactly one cycle; then IDLE unconditionally.
REQ-023 start while busy=1 SHALL be ignored; start in DONE cycle SHALL be ignored.
REQ-024 After a run, acc and carry SHALL hold their final values until the next accepted start or reset.
REQ-025 Operand latency: acc reflects an accepted operand on the cycle after the transfer edge; throughput one operand per cycle.
REQ-026 Maximum run: len = 2^LEN_W-1 operands; counter never wraps.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, acc=8'h00, carry=0, counter=0, in_ready=0, busy=0, done=0.
REQ-028 reset asserted mid-run SHALL abort it without a done pulse; after release the block waits in IDLE for start.

Configuration
REQ-029 Macro ACC_SAT_EN defined: on a transfer where cla8.co=1, acc<=8'hFF instead of s; carry still set; subsequent adds keep acc at 8'hFF.
REQ-030 ACC_SAT_EN undefined: acc wraps modulo 256 (REQ-019); carry is the only overflow indication.

Verification
REQ-031 Reset, start with len=3, operands 10,20,30 back-to-back -> acc=60, carry=0, done pulses one cycle on the cycle after the third transfer, busy low afterward.
REQ-032 len=2, operands 200,100 -> ACC_SAT_EN undefined: acc=44, carry=1; defined: acc=255, carry=1.
REQ-033 len=2, operand 5, in_valid low 4 cycles, operand 7 -> in_ready held high during the gap, acc=12, one done pulse.
REQ-034 start with len=0 -> DONE next cycle, done one-cycle pulse, acc=0, in_ready never high.
REQ-035 Start run len=4, accept 2 operands, assert reset -> acc=0, state IDLE, no done; start len=1 operand 9 -> acc=9.
REQ-036 start pulsed during ACCUM and during DONE with len=7 -> ignored; run completes with original len; in_valid held high in IDLE -> no transfer.
